// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared constants and the arbiter state encoding for the CPU/DMA memory
//   port arbiter. Imported by mem_bus_arbiter and sat_counter.
package mem_bus_arbiter_pkg;

  localparam int WORD_SIZE_DEF    = 16;  // data and address width
  localparam int BURST_MAX_DEF    = 12;  // DMA words per grant before forced release
  localparam int STARVE_LIMIT_DEF = 8;   // DMA wait cycles before DMA beats the CPU
  localparam int CNT_W_DEF        = 4;   // burst / starvation counter width

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_CPU_BUSY = 3'd1,
    ARB_CPU_RESP = 3'd2,
    ARB_DMA_OWN  = 3'd3,
    ARB_DMA_BUSY = 3'd4,
    ARB_DMA_RESP = 3'd5,
    ARB_DMA_REL  = 3'd6
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear. Clear has priority over
//   increment; the count holds at all-ones instead of wrapping.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clr        : synchronous clear
//   inc        : increment by one (ignored when saturated)
//   cnt        : current count
module sat_counter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory port between a CPU (single-word accesses) and a DMA
//   engine (bus-ownership bursts of up to BURST_MAX words). CPU has fixed
//   priority unless DMA has waited STARVE_LIMIT or more cycles.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ARB_IDLE     | bus free, arbitrate between cpu_req and dma_req
//   ARB_CPU_BUSY | CPU access on memory, strobes high until mem_ack
//   ARB_CPU_RESP | cpu_ready pulse, requests ignored
//   ARB_DMA_OWN  | DMA holds grant, waiting for a strobe or release
//   ARB_DMA_BUSY | DMA word on memory, strobes high until mem_ack
//   ARB_DMA_RESP | dma_ready pulse, back to DMA_OWN
//   ARB_DMA_REL  | grant dropped for one cycle, requests ignored
//
// Ports:
//   clk, reset                         : clock, async active-high reset
//   cpu_req/we/addr/wdata, cpu_rdata/ready : CPU access interface
//   dma_req, dma_grant                 : bus request / bus grant
//   dma_strobe/we/addr/wdata, dma_rdata/ready : DMA word interface
//   mem_read/write/addr/wdata, mem_rdata/ack  : memory wrapper interface
// All outputs are registered.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int BURST_MAX    = BURST_MAX_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [WORD_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_ready,
  input  logic                 dma_req,
  output logic                 dma_grant,
  input  logic                 dma_strobe,
  input  logic                 dma_we,
  input  logic [WORD_SIZE-1:0] dma_addr,
  input  logic [WORD_SIZE-1:0] dma_wdata,
  output logic [WORD_SIZE-1:0] dma_rdata,
  output logic                 dma_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack
);

  localparam logic [CNT_W-1:0] BURST_MAX_C    = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] STARVE_LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_e           state_q, state_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [WORD_SIZE-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [WORD_SIZE-1:0] dma_rdata_q, dma_rdata_d;
  logic                 cpu_ready_q, cpu_ready_d;
  logic                 dma_ready_q, dma_ready_d;
  logic                 dma_grant_q, dma_grant_d;

  logic                 burst_clr, burst_inc;
  logic                 starve_clr, starve_inc;
  logic [CNT_W-1:0]     burst_cnt;
  logic [CNT_W-1:0]     starve_cnt;
  logic                 starve_hit;

  sat_counter #(.CNT_W(CNT_W)) u_burst_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (burst_clr),
    .inc   (burst_inc),
    .cnt   (burst_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (starve_clr),
    .inc   (starve_inc),
    .cnt   (starve_cnt)
  );

  // Waiting is measured against the registered grant, so the cycles spent
  // in IDLE deciding and in DMA_REL also count as waiting (REL clears it).
  assign starve_inc = dma_req && !dma_grant_q;
  assign starve_clr = !dma_req || (state_q == ARB_DMA_REL);
  assign starve_hit = (starve_cnt >= STARVE_LIMIT_C);

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    dma_grant_d = dma_grant_q;
    burst_clr   = 1'b0;
    burst_inc   = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        dma_grant_d = 1'b0;
        if (dma_req && (!cpu_req || starve_hit)) begin
          state_d     = ARB_DMA_OWN;
          dma_grant_d = 1'b1;
          burst_clr   = 1'b1;
        end else if (cpu_req) begin
          state_d     = ARB_CPU_BUSY;
          mem_read_d  = !cpu_we;
          mem_write_d = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
        end
      end

      ARB_CPU_BUSY: begin
        if (mem_ack) begin
          state_d     = ARB_CPU_RESP;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          cpu_rdata_d = mem_rdata;
          cpu_ready_d = 1'b1;
        end
      end

      ARB_CPU_RESP: begin
        state_d = ARB_IDLE;
      end

      ARB_DMA_OWN: begin
        // Release (voluntary or forced) wins over a same-cycle strobe.
        if (!dma_req || (burst_cnt == BURST_MAX_C)) begin
          state_d     = ARB_DMA_REL;
          dma_grant_d = 1'b0;
        end else if (dma_strobe) begin
          state_d     = ARB_DMA_BUSY;
          mem_read_d  = !dma_we;
          mem_write_d = dma_we;
          mem_addr_d  = dma_addr;
          mem_wdata_d = dma_wdata;
        end
      end

      ARB_DMA_BUSY: begin
        if (mem_ack) begin
          state_d     = ARB_DMA_RESP;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          dma_rdata_d = mem_rdata;
          dma_ready_d = 1'b1;
          burst_inc   = 1'b1;
        end
      end

      ARB_DMA_RESP: begin
        state_d = ARB_DMA_OWN;
      end

      ARB_DMA_REL: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d     = ARB_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        dma_grant_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      dma_grant_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
      dma_grant_q <= dma_grant_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign dma_grant = dma_grant_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_ready = dma_ready_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter. A small memory model acks a strobe
//   after mem_lat extra cycles (mem_lat=0 acks in the first strobe cycle).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        dma_req = 1'b0, dma_strobe = 1'b0, dma_we = 1'b0;
  logic [15:0] dma_addr = '0, dma_wdata = '0;
  logic        dma_grant, dma_ready;
  logic [15:0] dma_rdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack;

  int          mem_lat = 0;
  int          wcnt;
  logic        ack_inject = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .dma_req    (dma_req),
    .dma_grant  (dma_grant),
    .dma_strobe (dma_strobe),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_rdata  (dma_rdata),
    .dma_ready  (dma_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always @(posedge clk or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (mem_read || mem_write) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  assign mem_ack = ((mem_read || mem_write) && (wcnt == mem_lat)) || ack_inject;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [85:0] outs;
    reset = 1'b1;
    #12;
    outs = {cpu_rdata, cpu_ready, dma_grant, dma_rdata, dma_ready,
            mem_read, mem_write, mem_addr, mem_wdata};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read();
    int rd_n = 0, rdy_n = 0;
    logic [15:0] got = '0, seen_addr = '0;
    mem_lat = 1; mem_rdata = 16'h1234;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040; cpu_wdata = 16'hDEAD;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_read) begin rd_n++; seen_addr = mem_addr; end
      if (cpu_ready) begin rdy_n++; got = cpu_rdata; cpu_req = 1'b0; end
    end
    vectors++;
    if (rd_n !== 2) begin miscompares++; $display("FAIL cpu_read_strobe_cycles: got %0d expected 2", rd_n); end
    vectors++;
    if (seen_addr !== 16'h0040) begin miscompares++; $display("FAIL cpu_read_addr: got %h expected 0040", seen_addr); end
    vectors++;
    if (rdy_n !== 1) begin miscompares++; $display("FAIL cpu_ready_width: got %0d expected 1", rdy_n); end
    vectors++;
    if (got !== 16'h1234) begin miscompares++; $display("FAIL cpu_rdata: got %h expected 1234", got); end
  endtask

  task automatic test_cpu_write();
    int wr_n = 0, rd_n = 0, rdy_at = 0;
    logic [15:0] seen_wdata = '0;
    mem_lat = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0080; cpu_wdata = 16'hBEEF;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (mem_write) begin wr_n++; seen_wdata = mem_wdata; end
      if (mem_read) rd_n++;
      if (cpu_ready) begin rdy_at = i; cpu_req = 1'b0; end
    end
    vectors++;
    if (wr_n !== 1 || rd_n !== 0) begin miscompares++; $display("FAIL cpu_write_strobes: got wr=%0d rd=%0d expected wr=1 rd=0", wr_n, rd_n); end
    vectors++;
    if (seen_wdata !== 16'hBEEF) begin miscompares++; $display("FAIL cpu_write_data: got %h expected beef", seen_wdata); end
    vectors++;
    if (rdy_at !== 2) begin miscompares++; $display("FAIL cpu_write_latency: got ready after edge %0d expected 2", rdy_at); end
  endtask

  task automatic test_dma_burst();
    int k = 0, wr_n = 0, rdy_n = 0, drop = 0, bad = 0, late_wr = 0;
    logic g1, g2, g3;
    mem_lat = 0;
    dma_req = 1'b1;
    while (!dma_grant && k < 10) begin tick(); k++; end
    vectors++;
    if (dma_grant !== 1'b1) begin miscompares++; $display("FAIL dma_burst_grant: got %b expected 1", dma_grant); end
    dma_we = 1'b1;
    for (int w = 0; w < 12; w++) begin
      dma_addr = 16'h01F4 + 16'(w); dma_wdata = 16'hD000 + 16'(w); dma_strobe = 1'b1;
      k = 0;
      while (k < 10) begin
        tick(); k++;
        if (!dma_grant) drop++;
        if (mem_write) begin
          wr_n++;
          if (mem_addr !== dma_addr || mem_wdata !== dma_wdata) bad++;
        end
        if (dma_ready) begin rdy_n++; break; end
      end
    end
    dma_addr = 16'h0200;
    tick(); g1 = dma_grant; if (mem_write) late_wr++;
    tick(); g2 = dma_grant; if (mem_write) late_wr++;
    tick(); g3 = dma_grant; if (mem_write) late_wr++;
    dma_req = 1'b0; dma_strobe = 1'b0;
    tick(); tick();
    vectors++;
    if (rdy_n !== 12) begin miscompares++; $display("FAIL dma_ready_pulses: got %0d expected 12", rdy_n); end
    vectors++;
    if (wr_n !== 12 || bad !== 0) begin miscompares++; $display("FAIL dma_burst_writes: got %0d writes %0d bad expected 12 writes 0 bad", wr_n, bad); end
    vectors++;
    if (drop !== 0) begin miscompares++; $display("FAIL dma_grant_held: got %0d low cycles expected 0", drop); end
    vectors++;
    if ({g1, g2, g3} !== 3'b100) begin miscompares++; $display("FAIL dma_forced_release: got %b expected 100", {g1, g2, g3}); end
    vectors++;
    if (late_wr !== 0) begin miscompares++; $display("FAIL dma_word_13: got %0d writes expected 0", late_wr); end
  endtask

  task automatic test_simultaneous();
    logic [3:0] grant_seq;
    logic       rd0, rdy1;
    mem_lat = 0; mem_rdata = 16'h5555;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0060; dma_req = 1'b1;
    tick(); rd0 = mem_read; grant_seq[0] = dma_grant;
    tick(); rdy1 = cpu_ready; grant_seq[1] = dma_grant; cpu_req = 1'b0;
    tick(); grant_seq[2] = dma_grant;
    tick(); grant_seq[3] = dma_grant;
    vectors++;
    if (rd0 !== 1'b1 || rdy1 !== 1'b1) begin miscompares++; $display("FAIL simul_cpu_first: got read=%b ready=%b expected 1 1", rd0, rdy1); end
    vectors++;
    if (grant_seq !== 4'b1000) begin miscompares++; $display("FAIL simul_dma_after: got %b expected 1000", grant_seq); end
    dma_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_starvation();
    int first = 0, rdy_n = 0, k = 0;
    logic rd_at_grant = 1'b1, served = 1'b0, g_at_serve = 1'b1;
    mem_lat = 0; mem_rdata = 16'h0007;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0070; dma_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cpu_ready) rdy_n++;
      if (dma_grant) begin first = i; rd_at_grant = mem_read; break; end
    end
    vectors++;
    if (first !== 10) begin miscompares++; $display("FAIL starve_grant_edge: got %0d expected 10", first); end
    vectors++;
    if (rdy_n !== 3) begin miscompares++; $display("FAIL starve_cpu_count: got %0d expected 3", rdy_n); end
    vectors++;
    if (rd_at_grant !== 1'b0) begin miscompares++; $display("FAIL starve_no_cpu_inflight: got %b expected 0", rd_at_grant); end
    dma_req = 1'b0;
    while (!served && k < 10) begin
      tick(); k++;
      if (cpu_ready) begin served = 1'b1; g_at_serve = dma_grant; end
    end
    vectors++;
    if (served !== 1'b1 || g_at_serve !== 1'b0) begin miscompares++; $display("FAIL starve_cpu_pending: got served=%b grant=%b expected 1 0", served, g_at_serve); end
    cpu_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_cpu_during_dma();
    int k = 0, bad = 0, start = 0;
    logic got_rdy = 1'b0;
    logic [15:0] rd = '0;
    logic [31:0] cpu_beat = '0;
    logic g_at_start = 1'b1;
    mem_lat = 3; mem_rdata = 16'h0BAD;
    dma_req = 1'b1;
    while (!dma_grant && k < 10) begin tick(); k++; end
    dma_we = 1'b0; dma_addr = 16'h0300; dma_strobe = 1'b1;
    tick();
    vectors++;
    if (mem_read !== 1'b1 || mem_addr !== 16'h0300) begin miscompares++; $display("FAIL busy_dma_start: got read=%b addr=%h expected 1 0300", mem_read, mem_addr); end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0050; cpu_wdata = 16'h7777;
    k = 0;
    while (!got_rdy && k < 15) begin
      tick(); k++;
      if (mem_addr !== 16'h0300 || mem_write) bad++;
      if (dma_ready) begin got_rdy = 1'b1; rd = dma_rdata; end
    end
    dma_strobe = 1'b0; dma_req = 1'b0;
    vectors++;
    if (got_rdy !== 1'b1 || rd !== 16'h0BAD) begin miscompares++; $display("FAIL busy_dma_rdata: got ready=%b data=%h expected 1 0bad", got_rdy, rd); end
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (mem_write) begin start = i; cpu_beat = {mem_addr, mem_wdata}; g_at_start = dma_grant; break; end
      if (mem_addr !== 16'h0300) bad++;
    end
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL busy_no_strobe_change: got %0d bad cycles expected 0", bad); end
    vectors++;
    if (start !== 4 || g_at_start !== 1'b0) begin miscompares++; $display("FAIL busy_cpu_after_rel: got edge %0d grant=%b expected 4 0", start, g_at_start); end
    vectors++;
    if (cpu_beat !== 32'h0050_7777) begin miscompares++; $display("FAIL busy_cpu_beat: got %h expected 00507777", cpu_beat); end
    got_rdy = 1'b0; k = 0;
    while (!got_rdy && k < 10) begin tick(); k++; if (cpu_ready) got_rdy = 1'b1; end
    cpu_req = 1'b0;
    vectors++;
    if (got_rdy !== 1'b1) begin miscompares++; $display("FAIL busy_cpu_done: got %b expected 1", got_rdy); end
    tick(); tick();
  endtask

  task automatic test_reset_mid_cpu();
    logic [85:0] outs;
    int late = 0;
    mem_lat = 6;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0090;
    tick(); tick();
    vectors++;
    if (mem_read !== 1'b1 || mem_addr !== 16'h0090) begin miscompares++; $display("FAIL rst_precondition: got read=%b addr=%h expected 1 0090", mem_read, mem_addr); end
    #2;
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    outs = {cpu_rdata, cpu_ready, dma_grant, dma_rdata, dma_ready,
            mem_read, mem_write, mem_addr, mem_wdata};
    vectors++;
    if (outs !== '0) begin miscompares++; $display("FAIL rst_async_outputs: got %h expected 0", outs); end
    @(negedge clk);
    reset = 1'b0;
    ack_inject = 1'b1;
    tick();
    ack_inject = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_ready || mem_read || mem_write) late++;
      tick();
    end
    vectors++;
    if (late !== 0) begin miscompares++; $display("FAIL rst_late_ack: got %0d active cycles expected 0", late); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_dma_burst();
    test_simultaneous();
    test_starvation();
    test_cpu_during_dma();
    test_reset_mid_cpu();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single memory port between the multi-cycle CPU and a DMA engine. The CPU issues single-word accesses. The DMA engine takes bus ownership for bursts of up to BURST_MAX words. Fixed CPU priority is overridden by an anti-starvation counter, so DMA is always eventually granted. Sits between the CPU/DMA memory interfaces and the memory wrapper.

Parameters:
WORD_SIZE, 16, data and address width
BURST_MAX, 12, maximum DMA words per grant before forced release
STARVE_LIMIT, 8, DMA wait cycles after which DMA beats a concurrent CPU request
CNT_W, 4, width of the burst and starvation counters (must hold BURST_MAX and STARVE_LIMIT)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, level; held with cpu_we/cpu_addr/cpu_wdata until cpu_ready
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  WORD_SIZE  CPU address
cpu_wdata  in  WORD_SIZE  CPU write data
cpu_rdata  out  WORD_SIZE  CPU read data, registered, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
dma_req  in  1  bus request (BR), level
dma_grant  out  1  bus grant (BG), registered
dma_strobe  in  1  DMA word access request, honoured only while dma_grant=1
dma_we  in  1  DMA write enable
dma_addr  in  WORD_SIZE  DMA address
dma_wdata  in  WORD_SIZE  DMA write data
dma_rdata  out  WORD_SIZE  DMA read data, registered
dma_ready  out  1  one-cycle DMA word completion pulse
mem_read  out  1  memory read strobe, registered
mem_write  out  1  memory write strobe, registered
mem_addr  out  WORD_SIZE  memory address, registered
mem_wdata  out  WORD_SIZE  memory write data, registered
mem_rdata  in  WORD_SIZE  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle pulse, access complete

Behaviour:
- Reset (async): state=IDLE; every output 0; burst and starvation counters 0. In-flight access is abandoned. mem_ack arriving in IDLE/DMA_OWN is ignored.
- States: IDLE, CPU_BUSY, CPU_RESP, DMA_OWN, DMA_BUSY, DMA_RESP, DMA_REL.
- IDLE:
  - cpu_req only -> CPU_BUSY.
  - dma_req only -> DMA_OWN.
  - Both: CPU wins unless starve_cnt >= STARVE_LIMIT, in which case DMA wins.
- CPU_BUSY: mem_read/mem_write = ~cpu_we/cpu_we; mem_addr and mem_wdata are latched on entry; strobes stay high until mem_ack. On mem_ack: strobes drop, mem_rdata is captured into cpu_rdata -> CPU_RESP.
- CPU_RESP: cpu_ready=1 for exactly one cycle; all requests are ignored -> IDLE. Minimum CPU access = 3 cycles with a zero-wait memory (ack in first BUSY cycle).
- DMA_OWN: dma_grant=1; burst_cnt cleared on entry from IDLE.
  - dma_req low -> DMA_REL.
  - burst_cnt == BURST_MAX -> DMA_REL (forced).
  - Otherwise, dma_strobe -> DMA_BUSY, latching dma_addr/dma_wdata/dma_we.
  - dma_req low and dma_strobe in the same cycle: release wins and the strobe is dropped.
- DMA_BUSY: same strobe rules as CPU_BUSY. On mem_ack: capture dma_rdata, burst_cnt+1 -> DMA_RESP.
- DMA_RESP: dma_ready=1 for one cycle -> DMA_OWN.
- DMA_REL: dma_grant=0 for one cycle; starve_cnt cleared -> IDLE. During this cycle, CPU requests are held off and DMA re-request is not granted.
- starve_cnt: increments (saturating at 2^CNT_W-1) each cycle dma_req=1 and dma_grant=0. Cleared in DMA_REL and whenever dma_req=0.
- dma_grant never drops inside DMA_BUSY/DMA_RESP; a word in flight always completes.
- The CPU is never preempted mid-access.

Decomposition:
- macro.v: WORD_SIZE, the 3-bit state encodings (ARB_IDLE … ARB_DMA_REL), and default BURST_MAX/STARVE_LIMIT.
- One sub-module, sat_counter (CNT_W wide; inc/clr; saturating), instantiated twice: burst_cnt and starve_cnt.

Test Plan:
- CPU read 0x0040, memory acks 2 cycles after strobe with 0x1234 -> mem_read high 2 cycles; cpu_rdata=0x1234 with cpu_ready pulse; cpu_ready high exactly 1 cycle.
- DMA burst of 12 writes 0x01F4..0x01FF -> dma_grant stays high across all 12; 12 dma_ready pulses; forced DMA_REL; dma_grant low ≥1 cycle even though dma_req is still high.
- cpu_req and dma_req asserted in the same cycle, starve_cnt=0 -> CPU served first; DMA granted the cycle after CPU_RESP.
- Back-to-back CPU requests with dma_req held high -> DMA granted once starve_cnt reaches 8, ahead of the pending CPU request.
- cpu_req arriving during DMA_BUSY -> no mem strobe change until DMA_REL; the CPU access then starts from IDLE.
- reset pulsed mid-CPU_BUSY -> all outputs 0 immediately; a late mem_ack does not produce cpu_ready.
